// File: rtl/if_id_stage_buffer.sv
// IF/ID stage buffer: carries instruction + PC+4 from fetch to decode under valid/ready, with flush.
// Define IF_ID_SKID_EN to add a second (skid) entry so that IN_READY comes from a register.
module if_id_stage_buffer #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [INSTR_W-1:0] IN_INSTR,
    input  logic [PC_W-1:0]    IN_PC4,
    input  logic               FLUSH,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [INSTR_W-1:0] OUT_INSTR,
    output logic [PC_W-1:0]    OUT_PC4,
    output logic [1:0]         OCCUPANCY
);

    logic               mainValid_q, mainValid_d;
    logic [INSTR_W-1:0] mainInstr_q, mainInstr_d;
    logic [PC_W-1:0]    mainPc4_q, mainPc4_d;
    logic               accept;
    logic               retire;
    logic               mainLoad;

    assign accept   = IN_VALID && IN_READY;
    assign retire   = mainValid_q && OUT_READY;
    assign mainLoad = !mainValid_q || retire;

`ifdef IF_ID_SKID_EN
    logic               skidValid_q, skidValid_d;
    logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;
    logic [PC_W-1:0]    skidPc4_q, skidPc4_d;

    // Ready depends only on stored state, so decode stalls never ripple combinationally into fetch.
    assign IN_READY  = !skidValid_q && !RESET;
    assign OCCUPANCY = {skidValid_q, mainValid_q && !skidValid_q};

    always_comb begin
        mainValid_d = mainValid_q;
        mainInstr_d = mainInstr_q;
        mainPc4_d   = mainPc4_q;
        skidValid_d = skidValid_q;
        skidInstr_d = skidInstr_q;
        skidPc4_d   = skidPc4_q;
        if (FLUSH) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (mainLoad) begin
            if (skidValid_q) begin
                mainValid_d = 1'b1;
                mainInstr_d = skidInstr_q;
                mainPc4_d   = skidPc4_q;
                skidValid_d = 1'b0;
            end else begin
                mainValid_d = accept;
                if (accept) begin
                    mainInstr_d = IN_INSTR;
                    mainPc4_d   = IN_PC4;
                end
            end
        end else if (accept) begin
            skidValid_d = 1'b1;
            skidInstr_d = IN_INSTR;
            skidPc4_d   = IN_PC4;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            skidValid_q <= 1'b0;
            skidInstr_q <= '0;
            skidPc4_q   <= '0;
        end else begin
            skidValid_q <= skidValid_d;
            skidInstr_q <= skidInstr_d;
            skidPc4_q   <= skidPc4_d;
        end
    end
`else
    assign IN_READY  = !RESET && (!mainValid_q || OUT_READY);
    assign OCCUPANCY = {1'b0, mainValid_q};

    always_comb begin
        mainValid_d = mainValid_q;
        mainInstr_d = mainInstr_q;
        mainPc4_d   = mainPc4_q;
        if (FLUSH) begin
            mainValid_d = 1'b0;
        end else if (mainLoad) begin
            mainValid_d = accept;
            if (accept) begin
                mainInstr_d = IN_INSTR;
                mainPc4_d   = IN_PC4;
            end
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mainValid_q <= 1'b0;
            mainInstr_q <= NOP_INSTR;
            mainPc4_q   <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            mainInstr_q <= mainInstr_d;
            mainPc4_q   <= mainPc4_d;
        end
    end

    // An empty main entry presents a bubble; PC+4 deliberately keeps its last value.
    assign OUT_VALID = mainValid_q;
    assign OUT_INSTR = mainValid_q ? mainInstr_q : NOP_INSTR;
    assign OUT_PC4   = mainPc4_q;

endmodule
